// File: rtl/pwm_pkg.sv
// Shared types for the PWM bank: per-channel settings payload and counter direction.
package pwm_pkg;

  localparam int unsigned PWM_CNT_W = 16;
  localparam int unsigned PWM_DIV_W = 8;

  typedef struct packed {
    logic [PWM_CNT_W-1:0] period;
    logic [PWM_CNT_W-1:0] duty;
    logic [PWM_DIV_W-1:0] div;
    logic                 invert;
    logic                 center;
  } pwm_cfg_t;

  localparam pwm_cfg_t PWM_CFG_RST = '0;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: prescaler, period counter, shadow/active settings, registered output.
// Center-aligned counting is built only when PWM_CENTER_EN is defined.
module pwm_channel
  import pwm_pkg::*;
(
  input  logic     clock,
  input  logic     reset_n,
  input  logic     i_enable,
  input  logic     i_update,
  input  pwm_cfg_t i_cfg,
  output logic     o_pwm,
  output logic     o_tick,
  output logic     o_pending
);

  pwm_cfg_t             r_act;
  pwm_cfg_t             r_shd;
  logic                 r_pending;
  logic [PWM_DIV_W-1:0] r_pre;
  logic [PWM_CNT_W-1:0] r_cnt;
  logic                 r_pwm;
  logic                 r_tick;

  logic                 w_tick;
  logic                 w_last;
  logic                 w_wrap;
  logic                 w_apply;
  logic                 w_raw;
  logic [PWM_CNT_W-1:0] w_cnt_nxt;

  assign w_tick  = i_enable && (r_pre == r_act.div);
  assign w_last  = (r_act.period != '0) && (r_cnt == r_act.period - PWM_CNT_W'(1));
  assign w_raw   = (r_act.duty != '0) &&
                   ((r_act.duty >= r_act.period) || (r_cnt < r_act.duty));
  // Shadow settings land at a period boundary, or at once when nothing is running.
  assign w_apply = r_pending && (w_wrap || !i_enable || (r_act.period == '0));

`ifdef PWM_CENTER_EN
  pwm_dir_e r_dir;
  pwm_dir_e w_dir_nxt;
  logic     w_center;

  assign w_center = r_act.center && (r_act.period > PWM_CNT_W'(1));
`else
  logic w_unused_center;
  assign w_unused_center = r_act.center;
`endif

  // Next counter value; the wrap is the edge-mode rollover or the down->up turn at 0.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_wrap    = 1'b0;
`ifdef PWM_CENTER_EN
    w_dir_nxt = r_dir;
    if (w_tick && w_center) begin
      if ((r_dir == DIR_UP) && !w_last) begin
        w_cnt_nxt = r_cnt + PWM_CNT_W'(1);
      end else begin
        w_cnt_nxt = r_cnt - PWM_CNT_W'(1);
        w_wrap    = (r_cnt == PWM_CNT_W'(1));
        w_dir_nxt = w_wrap ? DIR_UP : DIR_DOWN;
      end
    end else
`endif
    if (w_tick && w_last) begin
      w_cnt_nxt = '0;
      w_wrap    = 1'b1;
    end else if (w_tick && (r_act.period != '0)) begin
      w_cnt_nxt = r_cnt + PWM_CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_act     <= PWM_CFG_RST;
      r_shd     <= PWM_CFG_RST;
      r_pending <= 1'b0;
      r_pre     <= '0;
      r_cnt     <= '0;
      r_pwm     <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      if (i_update) begin
        r_shd <= i_cfg;
      end
      if (w_apply) begin
        r_act <= r_shd;
      end
      // A capture coinciding with an apply stays pending for the following boundary.
      r_pending <= i_update || (r_pending && !w_apply);
      r_tick    <= w_wrap;
      r_pwm     <= i_enable ? (w_raw ^ r_act.invert) : r_act.invert;
      if (!i_enable) begin
        r_pre <= '0;
        r_cnt <= '0;
      end else begin
        r_pre <= (w_tick || w_apply) ? '0 : r_pre + PWM_DIV_W'(1);
        r_cnt <= w_cnt_nxt;
      end
    end
  end

`ifdef PWM_CENTER_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dir <= DIR_UP;
    end else if (!i_enable || w_apply) begin
      r_dir <= DIR_UP;
    end else begin
      r_dir <= w_dir_nxt;
    end
  end
`endif

  assign o_pwm     = r_pwm;
  assign o_tick    = r_tick;
  assign o_pending = r_pending;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator: slices the packed setting buses into one pwm_channel each.
// Optional center-aligned mode is compiled in with PWM_CENTER_EN.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = PWM_CNT_W,
  parameter int unsigned DIV_W    = PWM_DIV_W
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       update,
  input  logic [CHANNELS*CNT_W-1:0] period,
  input  logic [CHANNELS*CNT_W-1:0] duty,
  input  logic [CHANNELS*DIV_W-1:0] div,
  input  logic [CHANNELS-1:0]       invert,
  input  logic [CHANNELS-1:0]       center,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic [CHANNELS-1:0]       period_tick,
  output logic [CHANNELS-1:0]       pending
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwm_cfg_t w_cfg;

    assign w_cfg = '{
      period: PWM_CNT_W'(period[g*CNT_W +: CNT_W]),
      duty:   PWM_CNT_W'(duty[g*CNT_W +: CNT_W]),
      div:    PWM_DIV_W'(div[g*DIV_W +: DIV_W]),
      invert: invert[g],
      center: center[g]
    };

    pwm_channel u_ch (
      .clock     (clock),
      .reset_n   (reset_n),
      .i_enable  (enable[g]),
      .i_update  (update[g]),
      .i_cfg     (w_cfg),
      .o_pwm     (pwm_out[g]),
      .o_tick    (period_tick[g]),
      .o_pending (pending[g])
    );
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: captures per-cycle output traces and compares them
// against hand-derived bit patterns (bit i = sample i cycles after the run starts).
module tb_pwm_bank;

  localparam int unsigned CH    = 2;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned DIV_W = 8;

  logic                   clock = 1'b0;
  logic                   reset_n;
  logic [CH-1:0]          enable;
  logic [CH-1:0]          update;
  logic [CH*CNT_W-1:0]    period;
  logic [CH*CNT_W-1:0]    duty;
  logic [CH*DIV_W-1:0]    div;
  logic [CH-1:0]          invert;
  logic [CH-1:0]          center;
  logic [CH-1:0]          pwm_out;
  logic [CH-1:0]          period_tick;
  logic [CH-1:0]          pending;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [63:0] pw, tk, pd;

  pwm_bank #(.CHANNELS(CH), .CNT_W(CNT_W), .DIV_W(DIV_W)) u_dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .update      (update),
    .period      (period),
    .duty        (duty),
    .div         (div),
    .invert      (invert),
    .center      (center),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .pending     (pending)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Disable the channel, capture settings, let them apply; checks the pending pulse.
  task automatic load(input int ch, input logic [15:0] p, input logic [15:0] d,
                      input logic [7:0] v, input logic inv, input logic cen);
    enable[ch]               = 1'b0;
    period[ch*CNT_W +: CNT_W] = p;
    duty[ch*CNT_W +: CNT_W]   = d;
    div[ch*DIV_W +: DIV_W]    = v;
    invert[ch]               = inv;
    center[ch]               = cen;
    update[ch]               = 1'b1;
    step();
    update[ch]               = 1'b0;
    check("load_pending_rise", 64'(pending[ch]), 64'd1);
    step();
    check("load_pending_fall", 64'(pending[ch]), 64'd0);
  endtask

  // Record n samples; optionally pulse update with a new duty at sample ua / ub.
  task automatic run(input int ch, input int n, input int ua, input logic [15:0] da,
                     input int ub, input logic [15:0] db);
    pw = '0;
    tk = '0;
    pd = '0;
    for (int i = 0; i < n; i++) begin
      pw[i] = pwm_out[ch];
      tk[i] = period_tick[ch];
      pd[i] = pending[ch];
      if (i == ua) begin
        duty[ch*CNT_W +: CNT_W] = da;
        update[ch]              = 1'b1;
      end else if (i == ub) begin
        duty[ch*CNT_W +: CNT_W] = db;
        update[ch]              = 1'b1;
      end else begin
        update[ch] = 1'b0;
      end
      step();
    end
    update[ch] = 1'b0;
  endtask

  task automatic start(input int ch);
    enable[ch] = 1'b1;
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = '0;
    update  = '0;
    period  = '0;
    duty    = '0;
    div     = '0;
    invert  = '0;
    center  = '0;
    repeat (3) step();
    check("rst_pwm", 64'(pwm_out), 64'd0);
    check("rst_tick", 64'(period_tick), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    reset_n = 1'b1;
    step();
    check("post_rst_pwm", 64'(pwm_out), 64'd0);

    // Period 10, duty 3, no prescale
    load(0, 16'd10, 16'd3, 8'd0, 1'b0, 1'b0);
    start(0);
    run(0, 20, -1, 16'd0, -1, 16'd0);
    check("p10d3_pwm", pw, 64'h1C07);
    check("p10d3_tick", tk, 64'h80200);

    // Prescaler div 3, period 4, duty 2: 16-clock period, 8 high
    load(0, 16'd4, 16'd2, 8'd3, 1'b0, 1'b0);
    start(0);
    run(0, 32, -1, 16'd0, -1, 16'd0);
    check("div3_pwm", pw, 64'h00FF00FF);
    check("div3_tick", tk, 64'h80008000);

    load(0, 16'd4, 16'd0, 8'd3, 1'b0, 1'b0);
    start(0);
    run(0, 32, -1, 16'd0, -1, 16'd0);
    check("duty0_low", pw, 64'h0);

    load(0, 16'd4, 16'd4, 8'd3, 1'b0, 1'b0);
    start(0);
    run(0, 32, -1, 16'd0, -1, 16'd0);
    check("duty_full_high", pw, 64'hFFFF_FFFF);

    // Mid-period update duty 3 -> 7
    load(0, 16'd10, 16'd3, 8'd0, 1'b0, 1'b0);
    start(0);
    run(0, 30, 4, 16'd7, -1, 16'd0);
    check("mid_upd_pwm", pw, 64'h7F1FC07);
    check("mid_upd_pending", pd, 64'h1E0);
    check("mid_upd_tick", tk, 64'h20080200);

    // Two updates in one period: only the last (8) is ever applied
    load(0, 16'd10, 16'd3, 8'd0, 1'b0, 1'b0);
    start(0);
    run(0, 30, 2, 16'd5, 5, 16'd8);
    check("two_upd_pwm", pw, 64'hFF3FC07);
    check("two_upd_pending", pd, 64'h1F8);

    // Update sampled on the wrap edge waits a full period
    load(0, 16'd10, 16'd3, 8'd0, 1'b0, 1'b0);
    start(0);
    run(0, 30, 8, 16'd6, -1, 16'd0);
    check("wrap_upd_pwm", pw, 64'h3F01C07);
    check("wrap_upd_pending", pd, 64'h7FE00);

    // Channel 1 independent, inverted, period 3 duty 1
    load(1, 16'd3, 16'd1, 8'd0, 1'b1, 1'b0);
    start(1);
    run(1, 12, -1, 16'd0, -1, 16'd0);
    check("ch1_inv_pwm", pw, 64'hDB6);
    check("ch1_tick", tk, 64'h924);

    // Disabled channel idles at its polarity
    load(0, 16'd10, 16'd3, 8'd0, 1'b1, 1'b0);
    step();
    check("idle_inv_pwm", 64'(pwm_out[0]), 64'd1);
    check("idle_tick", 64'(period_tick[0]), 64'd0);

`ifdef PWM_CENTER_EN
    load(0, 16'd5, 16'd2, 8'd0, 1'b0, 1'b1);
    start(0);
    run(0, 16, -1, 16'd0, -1, 16'd0);
    check("center_pwm", pw, 64'h8383);
    check("center_tick", tk, 64'h8080);
`endif

    // Asynchronous reset mid-period with an update pending
    load(0, 16'd10, 16'd5, 8'd0, 1'b0, 1'b0);
    start(0);
    step();
    update[0] = 1'b1;
    step();
    update[0] = 1'b0;
    check("pre_rst_pwm", 64'(pwm_out[0]), 64'd1);
    check("pre_rst_pending", 64'(pending[0]), 64'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_pwm", 64'(pwm_out), 64'd0);
    check("async_rst_pending", 64'(pending), 64'd0);
    #3;
    reset_n = 1'b1;
    step();
    check("after_rst_pwm", 64'(pwm_out[0]), 64'd0);
    check("after_rst_pending", 64'(pending[0]), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
